// File: rtl/mux2_1_2bit_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered data channel.
// Grants are burst-limited and the sink can stall the channel with ready_out.
module mux2_1_2bit_arbiter #(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              ready_out,
  output logic              gnt0,
  output logic              gnt1,
  output logic              selec,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [3:0]        burst_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t              state_reg, state_next;
  logic                ptr_reg, ptr_next;
  logic                gnt0_reg, gnt1_reg;
  logic                sel_reg, sel_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                valid_reg, valid_next;
  logic [3:0]          cnt_reg, cnt_next;

  logic                owner;
  logic                own_req;
  logic                oth_req;
  logic [DATA_W-1:0]   own_data;
  logic                release_grant;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      sel_reg   <= 1'b0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt0_reg  <= (state_next == GRANT0);
      gnt1_reg  <= (state_next == GRANT1);
      sel_reg   <= sel_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    cnt_next      = cnt_reg;
    release_grant = 1'b0;
    owner         = (state_reg == GRANT1);
    own_req       = owner ? req1 : req0;
    oth_req       = owner ? req0 : req1;
    own_data      = owner ? data1 : data0;

    case (state_reg)
      IDLE: begin
        // ptr_reg = 0 prefers requester 0 when both ask together
        if (req0 && (!req1 || !ptr_reg))
          state_next = GRANT0;
        else if (req1)
          state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!own_req) begin
          release_grant = 1'b1;
        end else if (ready_out) begin
          data_next  = own_data;
          valid_next = 1'b1;
          cnt_next   = cnt_reg + 4'd1;
          if (cnt_reg + 4'd1 >= MAX_CNT)
            release_grant = 1'b1;
        end
        if (release_grant) begin
          cnt_next = 4'd0;
          ptr_next = ~owner;
          if (oth_req)
            state_next = owner ? GRANT0 : GRANT1;
          else if (own_req)
            state_next = state_reg;
          else
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // select follows the grant and keeps its last value while idle
    case (state_next)
      GRANT0:  sel_next = 1'b0;
      GRANT1:  sel_next = 1'b1;
      default: sel_next = sel_reg;
    endcase
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign selec     = sel_reg;
  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign burst_cnt = cnt_reg;

endmodule

// File: tb/tb_mux2_1_2bit_arbiter.sv
// Directed bench: vector table for the default build, hand sequences for reset
// mid-burst and a MAX_BURST = 1 build.
module tb_mux2_1_2bit_arbiter;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       req0, req1, ready_out;
  logic [1:0] data0, data1;

  logic       gnt0, gnt1, selec, valid_out;
  logic [1:0] data_out;
  logic [3:0] burst_cnt;

  logic       b_gnt0, b_gnt1, b_selec, b_valid_out;
  logic [1:0] b_data_out;
  logic [3:0] b_burst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux2_1_2bit_arbiter #(.DATA_W(2), .MAX_BURST(4)) dut (
    .clk(clk), .reset_L(reset_L), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .ready_out(ready_out),
    .gnt0(gnt0), .gnt1(gnt1), .selec(selec), .data_out(data_out),
    .valid_out(valid_out), .burst_cnt(burst_cnt)
  );

  mux2_1_2bit_arbiter #(.DATA_W(2), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .reset_L(reset_L), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .ready_out(ready_out),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .selec(b_selec), .data_out(b_data_out),
    .valid_out(b_valid_out), .burst_cnt(b_burst_cnt)
  );

  typedef struct {
    logic       r0, r1;
    logic [1:0] d0, d1;
    logic       rdy;
    logic       g0, g1, sel;
    logic [1:0] dout;
    logic       v;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic g0, input logic g1, input logic sel,
                          input logic [1:0] dout, input logic v, input logic [3:0] cnt);
    chk({tag, " gnt0"}, {3'b0, gnt0}, {3'b0, g0});
    chk({tag, " gnt1"}, {3'b0, gnt1}, {3'b0, g1});
    chk({tag, " selec"}, {3'b0, selec}, {3'b0, sel});
    chk({tag, " data_out"}, {2'b0, data_out}, {2'b0, dout});
    chk({tag, " valid_out"}, {3'b0, valid_out}, {3'b0, v});
    chk({tag, " burst_cnt"}, burst_cnt, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              r0 r1 d0 d1 rdy | g0 g1 sel dout v cnt
    // single requester, four beats then re-grant
    vecs.push_back('{1, 0, 2, 0, 1,  1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 2, 0, 1,  1, 0, 0, 2, 1, 1});
    vecs.push_back('{1, 0, 2, 0, 1,  1, 0, 0, 2, 1, 2});
    vecs.push_back('{1, 0, 2, 0, 1,  1, 0, 0, 2, 1, 3});
    vecs.push_back('{1, 0, 2, 0, 1,  1, 0, 0, 2, 1, 0});
    // backpressure for three cycles
    vecs.push_back('{1, 0, 1, 0, 1,  1, 0, 0, 1, 1, 1});
    vecs.push_back('{1, 0, 3, 0, 0,  1, 0, 0, 1, 0, 1});
    vecs.push_back('{1, 0, 3, 0, 0,  1, 0, 0, 1, 0, 1});
    vecs.push_back('{1, 0, 3, 0, 0,  1, 0, 0, 1, 0, 1});
    vecs.push_back('{1, 0, 3, 0, 1,  1, 0, 0, 3, 1, 2});
    // early release hands over without a beat
    vecs.push_back('{0, 1, 2, 1, 1,  0, 1, 1, 3, 0, 0});
    vecs.push_back('{1, 1, 2, 1, 1,  0, 1, 1, 1, 1, 1});
    vecs.push_back('{0, 0, 2, 1, 1,  0, 0, 1, 1, 0, 0});
    // contention from idle: requester 0 preferred
    vecs.push_back('{1, 1, 1, 3, 1,  1, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 1, 1, 3, 1,  1, 0, 0, 1, 1, 1});
    vecs.push_back('{1, 1, 1, 3, 1,  1, 0, 0, 1, 1, 2});
    vecs.push_back('{1, 1, 1, 3, 1,  1, 0, 0, 1, 1, 3});
    vecs.push_back('{1, 1, 1, 3, 1,  0, 1, 1, 1, 1, 0});
    vecs.push_back('{1, 1, 1, 3, 1,  0, 1, 1, 3, 1, 1});
    vecs.push_back('{1, 1, 1, 3, 1,  0, 1, 1, 3, 1, 2});
    vecs.push_back('{1, 1, 1, 3, 1,  0, 1, 1, 3, 1, 3});
    vecs.push_back('{1, 1, 1, 3, 1,  1, 0, 0, 3, 1, 0});
    vecs.push_back('{1, 1, 1, 3, 1,  1, 0, 0, 1, 1, 1});

    reset_L = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 2'd0; data1 = 2'd0; ready_out = 1'b0;
    @(posedge clk); #1;
    chk_main("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      data0 = vecs[i].d0; data1 = vecs[i].d1; ready_out = vecs[i].rdy;
      @(posedge clk); #1;
      $display("vec %0d: gnt0=%b gnt1=%b selec=%b data_out=%0d valid_out=%b burst_cnt=%0d",
               i, gnt0, gnt1, selec, data_out, valid_out, burst_cnt);
      chk_main($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].sel,
               vecs[i].dout, vecs[i].v, vecs[i].cnt);
    end

    // reset asserted mid-GRANT1 with two beats taken
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    req1 = 1'b1; data1 = 2'd2; ready_out = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("pre-reset: gnt1=%b burst_cnt=%0d", gnt1, burst_cnt);
    chk_main("pre_reset", 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'd2);
    #2;
    reset_L = 1'b0;
    #1;
    $display("async reset: gnt1=%b selec=%b burst_cnt=%0d", gnt1, selec, burst_cnt);
    chk_main("async_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    chk_main("post_reset_idle", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    $display("regrant after reset: gnt1=%b valid_out=%b", gnt1, valid_out);
    chk_main("regrant1", 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk_main("first_beat1", 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'd1);

    // MAX_BURST = 1 build: per-beat alternation
    reset_L = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 2'd1; data1 = 2'd2; ready_out = 1'b1;
    @(posedge clk); #1;
    reset_L = 1'b1;
    @(posedge clk); #1;
    chk("b1 first gnt0", {3'b0, b_gnt0}, 4'd1);
    chk("b1 first selec", {3'b0, b_selec}, 4'd0);
    for (int i = 0; i < 6; i++) begin
      logic       exp_sel;
      logic [1:0] exp_dout;
      exp_sel  = (i % 2 == 0);
      exp_dout = (i % 2 == 0) ? 2'd1 : 2'd2;
      @(posedge clk); #1;
      $display("b1 beat %0d: selec=%b data_out=%0d valid_out=%b", i, b_selec, b_data_out, b_valid_out);
      chk($sformatf("b1 beat%0d selec", i), {3'b0, b_selec}, {3'b0, exp_sel});
      chk($sformatf("b1 beat%0d gnt1", i), {3'b0, b_gnt1}, {3'b0, exp_sel});
      chk($sformatf("b1 beat%0d data_out", i), {2'b0, b_data_out}, {2'b0, exp_dout});
      chk($sformatf("b1 beat%0d valid_out", i), {3'b0, b_valid_out}, 4'd1);
      chk($sformatf("b1 beat%0d burst_cnt", i), b_burst_cnt, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
